// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Busy is held for a fixed MULT_CYCLES or DIV_CYCLES after Start, counted by
// a down-counter. HI/LO update on the edge where Busy falls.
// Optional feature macro: MDU_MADD_EN enables madd/maddu (MDCtrl 7/8), which
// accumulate the product into {HI,LO}.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    input  logic [3:0]  MDCtrl,
    input  logic        MFSel,
    input  logic        Flush_E,
    output logic        Busy,
    output logic        Start,
    output logic [31:0] MDO_E
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned OW = 4;

    localparam logic [OW-1:0] OP_MULT  = OW'(1);
    localparam logic [OW-1:0] OP_MULTU = OW'(2);
    localparam logic [OW-1:0] OP_DIV   = OW'(3);
    localparam logic [OW-1:0] OP_DIVU  = OW'(4);
    localparam logic [OW-1:0] OP_MTHI  = OW'(5);
    localparam logic [OW-1:0] OP_MTLO  = OW'(6);
    localparam logic [OW-1:0] OP_MADD  = OW'(7);
    localparam logic [OW-1:0] OP_MADDU = OW'(8);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;

    logic            start_class;
    logic            is_div_op;
    logic signed [2*DW-1:0] prod_s;
    logic [2*DW-1:0] prod_u;
    logic [DW-1:0]   a_mag, b_mag, b_safe, b_mag_safe;
    logic [DW-1:0]   quot_u, rem_u, quot_m, rem_m, quot_s, rem_s;
`ifdef MDU_MADD_EN
    logic [2*DW-1:0] acc_s, acc_u;
`endif

    // Arithmetic on the latched operands; results are consumed on the final busy edge
    always_comb begin
        prod_s     = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});
        prod_u     = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
        a_mag      = a_q[DW-1] ? (~a_q + DW'(1)) : a_q;
        b_mag      = b_q[DW-1] ? (~b_q + DW'(1)) : b_q;
        b_safe     = (b_q == '0) ? DW'(1) : b_q;
        b_mag_safe = (b_mag == '0) ? DW'(1) : b_mag;
        quot_u     = a_q / b_safe;
        rem_u      = a_q % b_safe;
        quot_m     = a_mag / b_mag_safe;
        rem_m      = a_mag % b_mag_safe;
        // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000)
        quot_s     = (a_q[DW-1] ^ b_q[DW-1]) ? (~quot_m + DW'(1)) : quot_m;
        rem_s      = a_q[DW-1] ? (~rem_m + DW'(1)) : rem_m;
`ifdef MDU_MADD_EN
        acc_s      = {hi_q, lo_q} + 64'(prod_s);
        acc_u      = {hi_q, lo_q} + prod_u;
`endif
    end

    // Op decode: which MDCtrl values launch a multi-cycle operation
    always_comb begin
        start_class = (MDCtrl == OP_MULT) || (MDCtrl == OP_MULTU) ||
                      (MDCtrl == OP_DIV)  || (MDCtrl == OP_DIVU);
`ifdef MDU_MADD_EN
        start_class = start_class || (MDCtrl == OP_MADD) || (MDCtrl == OP_MADDU);
`endif
        is_div_op   = (MDCtrl == OP_DIV) || (MDCtrl == OP_DIVU);
    end

    // Next-state, counter and HI/LO update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        Start   = start_class && !Flush_E && (state_q == S_IDLE) && reset;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = MDCtrl;
                    a_d     = SrcA_E;
                    b_d     = SrcB_E;
                    cnt_d   = is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = S_BUSY;
                end else if (!Flush_E && (MDCtrl == OP_MTHI)) begin
                    hi_d = SrcA_E;
                end else if (!Flush_E && (MDCtrl == OP_MTLO)) begin
                    lo_d = SrcA_E;
                end
            end
            S_BUSY: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = 64'(prod_s);
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (b_q != '0) begin
                                lo_d = quot_s;
                                hi_d = rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != '0) begin
                                lo_d = quot_u;
                                hi_d = rem_u;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc_s;
                        OP_MADDU: {hi_d, lo_d} = acc_u;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Busy decodes the one-bit state flop; read port muxes HI/LO
    always_comb begin
        Busy  = (state_q == S_BUSY);
        MDO_E = MFSel ? hi_q : lo_q;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning Busy duration of mult/multu/madd/maddu in cycles (1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning Busy duration of div/divu in cycles (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SrcA_E  input  32  E-stage operand A, the same forwarded operand driven to the ALU.
REQ-006 SHALL have port SrcB_E  input  32  E-stage operand B, the same forwarded operand driven to the ALU.
REQ-007 SHALL have port MDCtrl  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, others none.
REQ-008 SHALL have port MFSel  input  1  read select: 0 LO, 1 HI.
REQ-009 SHALL have port Flush_E  input  1  kills the op presented this cycle.
REQ-010 SHALL have port Busy  output  1  registered; high while an operation is in flight.
REQ-011 SHALL have port Start  output  1  combinational; high when MDCtrl is 1-4 (or 7-8 if enabled), Flush_E low, and Busy low.
REQ-012 SHALL have port MDO_E  output  32  HI or LO per MFSel, muxed with ALU output AO_E downstream.

Function
REQ-013 Start SHALL latch SrcA_E/SrcB_E and op on that edge; Busy SHALL rise on the same edge.
REQ-014 Busy SHALL stay high exactly MULT_CYCLES or DIV_CYCLES cycles, driven by a down-counter loaded on Start.
REQ-015 HI/LO SHALL update on the edge where the counter reaches zero; Busy SHALL fall on that same edge.
REQ-016 MDO_E SHALL return old HI/LO while Busy; new values SHALL be visible the cycle after Busy falls.
REQ-017 The hazard unit stalls on (Start or Busy) with mfhi/mflo/MD op in E; the block SHALL not stall itself.
REQ-018 Start-class ops, mthi and mtlo presented while Busy SHALL be ignored with no state change.
REQ-019 mthi/mtlo with Busy low and Flush_E low SHALL write SrcA_E to HI/LO next edge, Busy unaffected.
REQ-020 mult SHALL form signed 64-bit product; multu unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-021 div/divu SHALL give LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0.
REQ-023 Divisor zero SHALL leave HI/LO unchanged yet hold Busy for full DIV_CYCLES.
REQ-024 Flush_E high SHALL suppress any new op that cycle; an in-flight op SHALL complete regardless.

Reset
REQ-025 reset low SHALL asynchronously clear HI, LO, counter, latched operands and Busy to 0.
REQ-026 Reset mid-operation SHALL abort it; HI/LO SHALL read 0 after reset deasserts.
REQ-027 Start SHALL stay low while reset is low.

Configuration
REQ-028 With macro MDU_MADD_EN defined, madd/maddu SHALL add the signed/unsigned 64-bit product to {HI,LO}, MULT_CYCLES latency.
REQ-029 Without MDU_MADD_EN, MDCtrl 7/8 SHALL act as none: Start low, no state change.

Verification
REQ-030 mult A=0xFAB6E829 B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xF56DD052.
REQ-031 multu A=0xFAB6E829 B=2 -> HI=0x00000001, LO=0xF56DD052 after 5 cycles.
REQ-032 div A=7 B=0xFFFFFFFE -> Busy 10 cycles, LO=0xFFFFFFFD, HI=1; divu A=100 B=7 -> LO=14, HI=2.
REQ-033 mthi 0x1234 at Busy cycle 3 of a mult -> ignored; mthi 0x1234 idle -> MFSel=1 reads 0x1234 next cycle.
REQ-034 div by zero after mtlo 0x55 -> Busy 10 cycles, LO stays 0x55; reset low at Busy cycle 2 -> Busy=0, HI=LO=0.
REQ-035 With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu A=1 B=1 -> HI=1, LO=0; without it -> Start low, HI/LO unchanged.
